// File: rtl/ahb_fifo_slv.sv
// AHB slave fronting a word-wide FIFO: DATA push/pop, STATUS, CTRL flush, optional THRESH.
// Define AHB_FIFO_SLV_IRQ_EN to add the THRESH register and the IRQ output.
module ahb_fifo_slv #(
  parameter int unsigned P_SLV_ID = 0,
  parameter int unsigned P_DEPTH  = 16,
  parameter int unsigned P_DELAY  = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
`ifdef AHB_FIFO_SLV_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic          dp_valid, dp_write;
  logic [1:0]    dp_off;
  logic [31:0]   mem [P_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          ready, accept, xfer_err, dp_end;
  logic          do_push, do_pop, do_flush;
  logic [1:0]    a_off;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HBURST};

  assign a_off     = HADDR[3:2];
  assign ready     = (state == S_IDLE) || (state == S_ERR2) || ((state == S_WAIT) && (wcnt == '0));
  assign accept    = HSEL && HREADYin && HTRANS[1];
  assign dp_end    = dp_valid && ready;
  assign do_push   = dp_end && dp_write && (dp_off == 2'd0);
  assign do_pop    = dp_end && !dp_write && (dp_off == 2'd0);
  assign do_flush  = dp_end && dp_write && (dp_off == 2'd2) && HWDATA[0];
  assign HREADYout = ready;
  assign HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

  // count_nxt already folds in the data phase completing this cycle, so it
  // doubles as the in-flight-adjusted count for over/underflow checks.
  always_comb begin
    count_nxt = count + CW'(do_push) - CW'(do_pop);
    if (do_flush) count_nxt = '0;
  end

  always_comb begin
    xfer_err = (HSIZE != 3'b010)
            || ((a_off == 2'd1) && HWRITE)
            || ((a_off == 2'd0) && HWRITE && (count_nxt == CW'(P_DEPTH)))
            || ((a_off == 2'd0) && !HWRITE && (count_nxt == '0));
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_WAIT:  if (wcnt != '0) wcnt_nxt = wcnt - 4'd1;
      S_ERR1:  state_nxt = S_ERR2;
      default: ;
    endcase
    if (ready) begin
      state_nxt = S_IDLE;
      if (accept) begin
        if (xfer_err) begin
          state_nxt = S_ERR1;
        end else if (P_DELAY != 0) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = 4'(P_DELAY);
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (ready) begin
        dp_valid <= accept && !xfer_err;
        dp_write <= HWRITE;
        dp_off   <= a_off;
      end
      count <= count_nxt;
      if (do_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= HWDATA;
  end

`ifdef AHB_FIFO_SLV_IRQ_EN
  logic [8:0] thresh, thresh_nxt;

  assign thresh_nxt = (dp_end && dp_write && (dp_off == 2'd3)) ? HWDATA[8:0] : thresh;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      thresh <= '0;
      IRQ    <= 1'b0;
    end else begin
      thresh <= thresh_nxt;
      IRQ    <= (thresh_nxt != '0) && (9'(count_nxt) >= thresh_nxt);
    end
  end
`endif

  always_comb begin
    HRDATA = '0;
    if (dp_end && !dp_write) begin
      case (dp_off)
        2'd0: HRDATA = mem[rd_ptr];
        2'd1: begin
          HRDATA[31:28] = 4'(P_SLV_ID);
          HRDATA[17]    = (count == CW'(P_DEPTH));
          HRDATA[16]    = (count == '0);
          HRDATA[8:0]   = 9'(count);
        end
`ifdef AHB_FIFO_SLV_IRQ_EN
        2'd3: HRDATA[8:0] = thresh;
`endif
        default: ;
      endcase
    end
  end

endmodule
